writeback_buffer: RTL and testbench

- Writeback stage directly downstream of the memory stage; consumes its registered outputs.
- Queues committed results in a small FIFO and drains them to the scalar register file, the CC register and the vector register file.
- Vector results are written one lane per cycle.
- Exports a pending-write scoreboard to decode and a back-pressure stall to memory.

---
 rtl/writeback_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_writeback_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
// Writeback buffer: queues committed results and drains them to the scalar, CC and vector
// register files, one vector lane per cycle. Optional macro: WB_RETIRE_COUNT_EN.
module writeback_buffer #(
    parameter int unsigned REG_WIDTH     = 16,
    parameter int unsigned VREG_WIDTH    = 64,
    parameter int unsigned VREG_ID_WIDTH = 6,
    parameter int unsigned PC_WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned LANES         = 4
) (
    input  logic                          I_CLOCK,
    input  logic                          I_RST_N,
    input  logic                          I_LOCK,
    input  logic                          I_MEM_Valid,
    input  logic [PC_WIDTH-1:0]           I_PC,
    input  logic [3:0]                    I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]          I_DestValue,
    input  logic                          I_RegWEn,
    input  logic [VREG_ID_WIDTH-1:0]      I_DestVRegIdx,
    input  logic [VREG_WIDTH-1:0]         I_VecDestValue,
    input  logic                          I_VRegWEn,
    input  logic [2:0]                    I_CCValue,
    input  logic                          I_CCWEn,
    input  logic                          I_GPUStallSignal,
    output logic                          O_WB_Stall,
    output logic                          O_RegWEn,
    output logic [3:0]                    O_RegIdx,
    output logic [REG_WIDTH-1:0]          O_RegData,
    output logic                          O_CCWEn,
    output logic [2:0]                    O_CCValue,
    output logic                          O_VLaneWEn,
    output logic [VREG_ID_WIDTH-1:0]      O_VRegIdx,
    output logic [$clog2(LANES)-1:0]      O_VLaneIdx,
    output logic [VREG_WIDTH/LANES-1:0]   O_VLaneData,
    output logic [15:0]                   O_PendingRegMask,
    output logic                          O_PendingCC,
    output logic                          O_Retire,
    output logic [PC_WIDTH-1:0]           O_RetirePC,
    output logic                          O_Overflow,
    output logic [15:0]                   O_RetireCount
);
    localparam int unsigned LANE_W = VREG_WIDTH / LANES;
    localparam int unsigned LIDX_W = $clog2(LANES);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]      pc;
        logic                     reg_wen;
        logic [3:0]               reg_idx;
        logic [REG_WIDTH-1:0]     reg_data;
        logic                     cc_wen;
        logic [2:0]               cc_value;
        logic                     vreg_wen;
        logic [VREG_ID_WIDTH-1:0] vreg_idx;
        logic [VREG_WIDTH-1:0]    vec_data;
    } entry_t;

    typedef struct packed {
        logic                     reg_wen;
        logic [3:0]               reg_idx;
        logic [REG_WIDTH-1:0]     reg_data;
        logic                     cc_wen;
        logic [2:0]               cc_value;
        logic                     vlane_wen;
        logic [VREG_ID_WIDTH-1:0] vreg_idx;
        logic [LIDX_W-1:0]        lane_idx;
        logic [LANE_W-1:0]        lane_data;
        logic                     retire;
        logic [PC_WIDTH-1:0]      retire_pc;
    } wb_out_t;

    typedef enum logic {StIdle, StVlane} state_t;

    entry_t                fifo_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    state_t                state_q, state_d;
    logic [LIDX_W-1:0]     lane_q, lane_d;
    logic                  overflow_q;
    wb_out_t               out_q, out_d;

    entry_t head, new_entry;
    logic   full, offer, push, pop;

    assign head  = fifo_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign offer = I_LOCK && I_MEM_Valid && (I_RegWEn || I_VRegWEn || I_CCWEn);
    assign push  = offer && !full;

    assign new_entry = '{pc: I_PC, reg_wen: I_RegWEn, reg_idx: I_DestRegIdx,
                         reg_data: I_DestValue, cc_wen: I_CCWEn, cc_value: I_CCValue,
                         vreg_wen: I_VRegWEn, vreg_idx: I_DestVRegIdx,
                         vec_data: I_VecDestValue};

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        pop     = 1'b0;
        out_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && !I_GPUStallSignal) begin
                    out_d.reg_wen  = head.reg_wen;
                    out_d.reg_idx  = head.reg_wen ? head.reg_idx : '0;
                    out_d.reg_data = head.reg_wen ? head.reg_data : '0;
                    out_d.cc_wen   = head.cc_wen;
                    out_d.cc_value = head.cc_wen ? head.cc_value : '0;
                    if (head.vreg_wen) begin
                        out_d.vlane_wen = 1'b1;
                        out_d.vreg_idx  = head.vreg_idx;
                        out_d.lane_data = LANE_W'(head.vec_data);
                        state_d         = StVlane;
                        lane_d          = LIDX_W'(1);
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            StVlane: begin
                // The head stays queued (and visible to the scoreboard) until its last lane.
                if (!I_GPUStallSignal) begin
                    out_d.vlane_wen = 1'b1;
                    out_d.vreg_idx  = head.vreg_idx;
                    out_d.lane_idx  = lane_q;
                    out_d.lane_data = LANE_W'(head.vec_data >> (LANE_W * lane_q));
                    if (lane_q == LIDX_W'(LANES - 1)) begin
                        pop     = 1'b1;
                        state_d = StIdle;
                        lane_d  = '0;
                    end else begin
                        lane_d = lane_q + LIDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        out_d.retire    = pop;
        out_d.retire_pc = pop ? head.pc : '0;
    end

    always_ff @(negedge I_CLOCK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            lane_q     <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            out_q   <= out_d;
            if (offer && full) overflow_q <= 1'b1;
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                fifo_q[wr_ptr_q]  <= new_entry;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        O_PendingRegMask = '0;
        O_PendingCC      = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i] && fifo_q[i].reg_wen) O_PendingRegMask[fifo_q[i].reg_idx] = 1'b1;
            if (valid_q[i] && fifo_q[i].cc_wen) O_PendingCC = 1'b1;
        end
    end

    assign O_WB_Stall  = full;
    assign O_Overflow  = overflow_q;
    assign O_RegWEn    = out_q.reg_wen;
    assign O_RegIdx    = out_q.reg_idx;
    assign O_RegData   = out_q.reg_data;
    assign O_CCWEn     = out_q.cc_wen;
    assign O_CCValue   = out_q.cc_value;
    assign O_VLaneWEn  = out_q.vlane_wen;
    assign O_VRegIdx   = out_q.vreg_idx;
    assign O_VLaneIdx  = out_q.lane_idx;
    assign O_VLaneData = out_q.lane_data;
    assign O_Retire    = out_q.retire;
    assign O_RetirePC  = out_q.retire_pc;

`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] retire_cnt_q;

    always_ff @(negedge I_CLOCK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            retire_cnt_q <= '0;
        end else if (pop) begin
            retire_cnt_q <= retire_cnt_q + 16'd1;
        end
    end

    assign O_RetireCount = retire_cnt_q;
`else
    assign O_RetireCount = '0;
`endif

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed vector table, corner-case sequences and random traffic
// checked against a queue-based reference model.
module tb_writeback_buffer;
    localparam int DEPTH = 4;
    localparam int LANES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock, mem_valid, rwen, vwen, ccwen, gstall;
    logic [15:0] pc, rdata;
    logic [3:0]  ridx;
    logic [5:0]  vidx;
    logic [63:0] vdata;
    logic [2:0]  ccv;

    logic        wb_stall, o_rwen, o_ccwen, o_vlwen, o_pcc, o_ret, o_ovf;
    logic [3:0]  o_ridx;
    logic [15:0] o_rdata, o_ldata, o_mask, o_rpc, o_rcnt;
    logic [2:0]  o_cc;
    logic [5:0]  o_vidx;
    logic [1:0]  o_lane;

    writeback_buffer dut (
        .I_CLOCK(clk), .I_RST_N(rst_n), .I_LOCK(lock), .I_MEM_Valid(mem_valid), .I_PC(pc),
        .I_DestRegIdx(ridx), .I_DestValue(rdata), .I_RegWEn(rwen), .I_DestVRegIdx(vidx),
        .I_VecDestValue(vdata), .I_VRegWEn(vwen), .I_CCValue(ccv), .I_CCWEn(ccwen),
        .I_GPUStallSignal(gstall), .O_WB_Stall(wb_stall), .O_RegWEn(o_rwen),
        .O_RegIdx(o_ridx), .O_RegData(o_rdata), .O_CCWEn(o_ccwen), .O_CCValue(o_cc),
        .O_VLaneWEn(o_vlwen), .O_VRegIdx(o_vidx), .O_VLaneIdx(o_lane),
        .O_VLaneData(o_ldata), .O_PendingRegMask(o_mask), .O_PendingCC(o_pcc),
        .O_Retire(o_ret), .O_RetirePC(o_rpc), .O_Overflow(o_ovf), .O_RetireCount(o_rcnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int lane_writes = 0;

    typedef struct {
        logic [15:0] pc;
        logic        rw;
        logic [3:0]  ri;
        logic [15:0] rd;
        logic        cw;
        logic [2:0]  cv;
        logic        vw;
        logic [5:0]  vi;
        logic [63:0] vd;
    } ent_t;

    ent_t q[$];
    int   prog;
    int   retired;
    logic m_ovf;
    logic        e_rw, e_cw, e_vl, e_ret, e_stall, e_pcc;
    logic [3:0]  e_ri;
    logic [15:0] e_rd, e_ld, e_rpc, e_mask, e_rcnt;
    logic [2:0]  e_cv;
    logic [5:0]  e_vi;
    logic [1:0]  e_ln;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic clear_expect();
        e_rw = 0; e_ri = '0; e_rd = '0; e_cw = 0; e_cv = '0; e_vl = 0; e_vi = '0;
        e_ln = '0; e_ld = '0; e_ret = 0; e_rpc = '0;
    endtask

    task automatic model_reset();
        q.delete();
        prog = 0; retired = 0; m_ovf = 0;
        clear_expect();
        e_stall = 0; e_mask = '0; e_pcc = 0; e_rcnt = '0;
    endtask

    // One clock of the reference behaviour: retire from the old queue, then accept.
    task automatic model_step();
        ent_t h;
        ent_t n;
        logic full_before;
        logic offered;
        logic do_pop;
        clear_expect();
        full_before = (q.size() == DEPTH);
        do_pop = 0;
        if (q.size() > 0 && !gstall) begin
            h = q[0];
            if (prog == 0) begin
                if (h.rw) begin e_rw = 1; e_ri = h.ri; e_rd = h.rd; end
                if (h.cw) begin e_cw = 1; e_cv = h.cv; end
            end
            if (h.vw) begin
                e_vl = 1; e_vi = h.vi; e_ln = 2'(prog);
                e_ld = 16'(h.vd >> (16 * prog));
                prog++;
                if (prog == LANES) begin prog = 0; do_pop = 1; end
            end else begin
                do_pop = 1;
            end
            if (do_pop) begin e_ret = 1; e_rpc = h.pc; retired++; end
        end
        offered = lock && mem_valid && (rwen || vwen || ccwen);
        if (offered && full_before) m_ovf = 1;
        if (offered && !full_before) begin
            n.pc = pc; n.rw = rwen; n.ri = ridx; n.rd = rdata; n.cw = ccwen; n.cv = ccv;
            n.vw = vwen; n.vi = vidx; n.vd = vdata;
            q.push_back(n);
        end
        if (do_pop) void'(q.pop_front());
        e_stall = (q.size() == DEPTH);
        e_mask = '0; e_pcc = 0;
        foreach (q[i]) begin
            if (q[i].rw) e_mask[q[i].ri] = 1'b1;
            if (q[i].cw) e_pcc = 1'b1;
        end
`ifdef WB_RETIRE_COUNT_EN
        e_rcnt = 16'(retired);
`else
        e_rcnt = '0;
`endif
    endtask

    task automatic check_model();
        chk("wb_stall", 64'(wb_stall), 64'(e_stall));
        chk("reg_wen", 64'(o_rwen), 64'(e_rw));
        chk("reg_idx", 64'(o_ridx), 64'(e_ri));
        chk("reg_data", 64'(o_rdata), 64'(e_rd));
        chk("cc_wen", 64'(o_ccwen), 64'(e_cw));
        chk("cc_value", 64'(o_cc), 64'(e_cv));
        chk("vlane_wen", 64'(o_vlwen), 64'(e_vl));
        chk("vreg_idx", 64'(o_vidx), 64'(e_vi));
        chk("vlane_idx", 64'(o_lane), 64'(e_ln));
        chk("vlane_data", 64'(o_ldata), 64'(e_ld));
        chk("retire", 64'(o_ret), 64'(e_ret));
        chk("retire_pc", 64'(o_rpc), 64'(e_rpc));
        chk("pending_mask", 64'(o_mask), 64'(e_mask));
        chk("pending_cc", 64'(o_pcc), 64'(e_pcc));
        chk("overflow", 64'(o_ovf), 64'(m_ovf));
        chk("retire_count", 64'(o_rcnt), 64'(e_rcnt));
    endtask

    task automatic set_idle();
        mem_valid = 0; lock = 1; rwen = 0; ridx = '0; rdata = '0; vwen = 0; vidx = '0;
        vdata = '0; ccwen = 0; ccv = '0; pc = '0; gstall = 0;
    endtask

    task automatic offer_entry(input logic rw, input logic [3:0] ri, input logic [15:0] rd,
                               input logic vw, input logic [5:0] vi, input logic [63:0] vd,
                               input logic cw, input logic [2:0] cv, input logic [15:0] p);
        mem_valid = 1; rwen = rw; ridx = ri; rdata = rd; vwen = vw; vidx = vi; vdata = vd;
        ccwen = cw; ccv = cv; pc = p;
    endtask

    // Inputs change just after the posedge; DUT acts on the negedge; outputs sampled after posedge.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        check_model();
        if (o_vlwen) lane_writes++;
    endtask

    task automatic hard_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        @(posedge clk);
        #1;
        check_model();
        rst_n = 1;
    endtask

    typedef struct {
        logic v; logic rw; logic [3:0] ri; logic [15:0] rd; logic vw; logic [5:0] vi;
        logic [63:0] vd; logic cw; logic [2:0] cv; logic [15:0] pc;
        logic e_rw; logic [3:0] e_ri; logic [15:0] e_rd; logic e_vl; logic [5:0] e_vi;
        logic [1:0] e_ln; logic [15:0] e_ld; logic e_cw; logic [2:0] e_cv; logic e_ret;
        logic [15:0] e_rpc; logic [15:0] e_mask; logic e_pcc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs: v rw ri rd vw vi vd cw cv pc | rw ri rd vl vi ln ld cw cv ret rpc mask pcc
        tbl[0]  = '{'1, '1, 4'd3, 16'h1234, '0, '0, '0, '0, '0, 16'h0100,
                    '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h0008, '0};
        tbl[1]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '1, 4'd3, 16'h1234, '0, '0, '0, '0, '0, '0, '1, 16'h0100, '0, '0};
        tbl[2]  = '{'1, '0, '0, '0, '1, 6'd5, 64'hDDDD_CCCC_BBBB_AAAA, '0, '0, 16'h0104,
                    '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};
        tbl[3]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd5, 2'd0, 16'hAAAA, '0, '0, '0, '0, '0, '0};
        tbl[4]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd5, 2'd1, 16'hBBBB, '0, '0, '0, '0, '0, '0};
        tbl[5]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd5, 2'd2, 16'hCCCC, '0, '0, '0, '0, '0, '0};
        tbl[6]  = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd5, 2'd3, 16'hDDDD, '0, '0, '1, 16'h0104, '0, '0};
        tbl[7]  = '{'1, '0, '0, '0, '0, '0, '0, '1, 3'd5, 16'h0108,
                    '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1};
        tbl[8]  = '{'1, '0, '0, '0, '0, '0, '0, '0, '0, 16'h010C,
                    '0, '0, '0, '0, '0, '0, '0, '1, 3'd5, '1, 16'h0108, '0, '0};
        tbl[9]  = '{'1, '1, 4'd7, 16'hBEEF, '1, 6'd2, 64'h4444_3333_2222_1111, '0, '0, 16'h0110,
                    '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 16'h0080, '0};
        tbl[10] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '1, 4'd7, 16'hBEEF, '1, 6'd2, 2'd0, 16'h1111, '0, '0, '0, '0, 16'h0080, '0};
        tbl[11] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd2, 2'd1, 16'h2222, '0, '0, '0, '0, 16'h0080, '0};
        tbl[12] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd2, 2'd2, 16'h3333, '0, '0, '0, '0, 16'h0080, '0};
        tbl[13] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '1, 6'd2, 2'd3, 16'h4444, '0, '0, '1, 16'h0110, '0, '0};
        tbl[14] = '{'0, '0, '0, '0, '0, '0, '0, '0, '0, '0,
                    '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0};

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            set_idle();
            mem_valid = tbl[i].v; rwen = tbl[i].rw; ridx = tbl[i].ri; rdata = tbl[i].rd;
            vwen = tbl[i].vw; vidx = tbl[i].vi; vdata = tbl[i].vd; ccwen = tbl[i].cw;
            ccv = tbl[i].cv; pc = tbl[i].pc;
            cycle();
            chk($sformatf("tbl%0d_reg_wen", i), 64'(o_rwen), 64'(tbl[i].e_rw));
            chk($sformatf("tbl%0d_reg_idx", i), 64'(o_ridx), 64'(tbl[i].e_ri));
            chk($sformatf("tbl%0d_reg_data", i), 64'(o_rdata), 64'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_vlane_wen", i), 64'(o_vlwen), 64'(tbl[i].e_vl));
            chk($sformatf("tbl%0d_vreg_idx", i), 64'(o_vidx), 64'(tbl[i].e_vi));
            chk($sformatf("tbl%0d_lane_idx", i), 64'(o_lane), 64'(tbl[i].e_ln));
            chk($sformatf("tbl%0d_lane_data", i), 64'(o_ldata), 64'(tbl[i].e_ld));
            chk($sformatf("tbl%0d_cc_wen", i), 64'(o_ccwen), 64'(tbl[i].e_cw));
            chk($sformatf("tbl%0d_cc_value", i), 64'(o_cc), 64'(tbl[i].e_cv));
            chk($sformatf("tbl%0d_retire", i), 64'(o_ret), 64'(tbl[i].e_ret));
            chk($sformatf("tbl%0d_retire_pc", i), 64'(o_rpc), 64'(tbl[i].e_rpc));
            chk($sformatf("tbl%0d_mask", i), 64'(o_mask), 64'(tbl[i].e_mask));
            chk($sformatf("tbl%0d_pending_cc", i), 64'(o_pcc), 64'(tbl[i].e_pcc));
        end

        // Fill while draining is frozen, overflow, then drain in order.
        set_idle();
        gstall = 1;
        for (int i = 1; i <= 4; i++) begin
            offer_entry(1, 4'(i), 16'(i * 16'h0111), 0, '0, '0, 0, '0, 16'(16'h0200 + i));
            cycle();
        end
        chk("full_stall", 64'(wb_stall), 64'd1);
        offer_entry(1, 4'd9, 16'h9999, 0, '0, '0, 0, '0, 16'h0209);
        cycle();
        chk("overflow_set", 64'(o_ovf), 64'd1);
        chk("fifth_not_queued", 64'(o_mask), 64'h001E);
        set_idle();
        cycle();
        chk("stall_drops_after_pop", 64'(wb_stall), 64'd0);
        chk("first_retire_pc", 64'(o_rpc), 64'h0201);
        repeat (4) cycle();
        chk("drained_mask", 64'(o_mask), 64'd0);
        chk("overflow_sticky", 64'(o_ovf), 64'd1);
        hard_reset();

        // Freeze in the middle of a vector write.
        set_idle();
        lane_writes = 0;
        offer_entry(0, '0, '0, 1, 6'd9, 64'h4321_8765_CAFE_F00D, 0, '0, 16'h0300);
        cycle();
        set_idle();
        cycle();
        cycle();
        chk("lane1_before_freeze", 64'(o_lane), 64'd1);
        gstall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("no_wen_while_frozen", 64'({o_rwen, o_ccwen, o_vlwen}), 64'd0);
        end
        gstall = 0;
        cycle();
        chk("resume_lane2", 64'(o_lane), 64'd2);
        chk("resume_lane2_data", 64'(o_ldata), 64'h8765);
        cycle();
        cycle();
        chk("frozen_vector_lane_writes", 64'(lane_writes), 64'd4);

        // Asynchronous reset while lane 2 is on the port.
        offer_entry(1, 4'd6, 16'h0666, 1, 6'd12, 64'h0DDD_0CCC_0BBB_0AAA, 1, 3'd2, 16'h0400);
        cycle();
        set_idle();
        repeat (3) cycle();
        chk("lane2_before_reset", 64'(o_lane), 64'd2);
        hard_reset();
        set_idle();
        lane_writes = 0;
        repeat (5) cycle();
        chk("no_lane_after_reset", 64'(lane_writes), 64'd0);

        // Random traffic, including lock drops and drain freezes.
        for (int n = 0; n < 400; n++) begin
            gstall    = ($urandom_range(0, 4) == 0);
            lock      = ($urandom_range(0, 6) != 0);
            mem_valid = ($urandom_range(0, 9) < 6);
            rwen      = 1'($urandom);
            ridx      = 4'($urandom);
            rdata     = 16'($urandom);
            vwen      = ($urandom_range(0, 3) == 0);
            vidx      = 6'($urandom);
            vdata     = {$urandom, $urandom};
            ccwen     = 1'($urandom);
            ccv       = 3'($urandom);
            pc        = 16'($urandom);
            cycle();
        end
        set_idle();
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
